// File: rtl/msgpass_buffer_arb.sv
// Dual-write / dual-read message buffer with self-zeroing init and port-A-wins write arbitration.
// Build option: define MSGPASS_BUFF_FWD_EN to forward same-cycle committed write data to reads.
module msgpass_buffer_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst,
   output logic                  init_busy_o,
   input  logic                  wen_a_i,
   input  logic                  wen_b_i,
   input  logic [ADDR_WIDTH-1:0] waddr_a_i,
   input  logic [ADDR_WIDTH-1:0] waddr_b_i,
   input  logic [DATA_WIDTH-1:0] wdata_a_i,
   input  logic [DATA_WIDTH-1:0] wdata_b_i,
   input  logic                  ren_a_i,
   input  logic                  ren_b_i,
   input  logic [ADDR_WIDTH-1:0] raddr_a_i,
   input  logic [ADDR_WIDTH-1:0] raddr_b_i,
   output logic [DATA_WIDTH-1:0] rdata_a_o,
   output logic [DATA_WIDTH-1:0] rdata_b_o,
   output logic                  rvalid_a_o,
   output logic                  rvalid_b_o,
   output logic                  conflict_o,
   output logic [CNT_WIDTH-1:0]  conflict_cnt_o,
   output logic [0:0]            dbg_state_o
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  run;
   logic                  drop_b;
   logic                  commit_a;
   logic                  commit_b;
   logic [DATA_WIDTH-1:0] rd_word_a;
   logic [DATA_WIDTH-1:0] rd_word_b;

   assign run         = (state == ST_RUN);
   assign init_busy_o = (state == ST_INIT);
   assign dbg_state_o = state;

   // Port A always wins a same-address collision; port B's write is the one dropped.
   assign drop_b   = run && wen_a_i && wen_b_i && (waddr_a_i == waddr_b_i);
   assign commit_a = run && wen_a_i;
   assign commit_b = run && wen_b_i && !drop_b;

`ifdef MSGPASS_BUFF_FWD_EN
   always_comb begin
      rd_word_a = mem[raddr_a_i];
      if (commit_a && (waddr_a_i == raddr_a_i))
         rd_word_a = wdata_a_i;
      else if (commit_b && (waddr_b_i == raddr_a_i))
         rd_word_a = wdata_b_i;
   end

   always_comb begin
      rd_word_b = mem[raddr_b_i];
      if (commit_a && (waddr_a_i == raddr_b_i))
         rd_word_b = wdata_a_i;
      else if (commit_b && (waddr_b_i == raddr_b_i))
         rd_word_b = wdata_b_i;
   end
`else
   assign rd_word_a = mem[raddr_a_i];
   assign rd_word_b = mem[raddr_b_i];
`endif

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state     <= ST_INIT;
         init_addr <= '0;
      end else if (state == ST_INIT) begin
         init_addr <= init_addr + ADDR_WIDTH'(1);
         if (init_addr == ADDR_WIDTH'(DEPTH - 1))
            state <= ST_RUN;
      end
   end

   // Storage has no reset of its own; the INIT sweep is what clears it.
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         if (state == ST_INIT) begin
            mem[init_addr] <= '0;
         end else begin
            if (commit_b) mem[waddr_b_i] <= wdata_b_i;
            if (commit_a) mem[waddr_a_i] <= wdata_a_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         rdata_a_o  <= '0;
         rdata_b_o  <= '0;
         rvalid_a_o <= 1'b0;
         rvalid_b_o <= 1'b0;
      end else begin
         rvalid_a_o <= run && ren_a_i;
         rvalid_b_o <= run && ren_b_i;
         if (run && ren_a_i) rdata_a_o <= rd_word_a;
         if (run && ren_b_i) rdata_b_o <= rd_word_b;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         conflict_o     <= 1'b0;
         conflict_cnt_o <= '0;
      end else begin
         conflict_o <= drop_b;
         if (drop_b && (conflict_cnt_o != {CNT_WIDTH{1'b1}}))
            conflict_cnt_o <= conflict_cnt_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_msgpass_buffer_arb.sv
// Self-checking bench for msgpass_buffer_arb (DEPTH=64, CNT_WIDTH=2); follows MSGPASS_BUFF_FWD_EN.
module tb_msgpass_buffer_arb;

   localparam int DW    = 8;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int CW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_busy;
   logic          wen_a, wen_b, ren_a, ren_b;
   logic [AW-1:0] waddr_a, waddr_b, raddr_a, raddr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic [DW-1:0] rdata_a, rdata_b;
   logic          rvalid_a, rvalid_b, conflict;
   logic [CW-1:0] conflict_cnt;
   logic [0:0]    dbg_state;

   msgpass_buffer_arb #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst(rst), .init_busy_o(init_busy),
      .wen_a_i(wen_a), .wen_b_i(wen_b),
      .waddr_a_i(waddr_a), .waddr_b_i(waddr_b),
      .wdata_a_i(wdata_a), .wdata_b_i(wdata_b),
      .ren_a_i(ren_a), .ren_b_i(ren_b),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .rdata_a_o(rdata_a), .rdata_b_o(rdata_b),
      .rvalid_a_o(rvalid_a), .rvalid_b_o(rvalid_b),
      .conflict_o(conflict), .conflict_cnt_o(conflict_cnt),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_q_a[$];
   logic [DW-1:0] exp_q_b[$];
   logic [DW-1:0] last_a, last_b;
   int            init_cnt;
   logic [CW-1:0] cnt_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic do_reset(input logic rd_pending);
      rst     = 1'b1;
      wen_a   = 1'b1; waddr_a = AW'($urandom_range(0, DEPTH-1)); wdata_a = 8'hEE;
      wen_b   = 1'b1; waddr_b = waddr_a; wdata_b = 8'hDD;
      ren_a   = rd_pending; raddr_a = 6'd9;
      ren_b   = rd_pending; raddr_b = 6'd5;
      @(posedge clk); #1;
      check("rst_busy", 32'(init_busy), 32'd1);
      check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
      check("rst_rvalid_b", 32'(rvalid_b), 32'd0);
      check("rst_rdata_a", 32'(rdata_a), 32'd0);
      check("rst_rdata_b", 32'(rdata_b), 32'd0);
      check("rst_conflict", 32'(conflict), 32'd0);
      check("rst_cnt", 32'(conflict_cnt), 32'd0);
      rst = 1'b0;
      exp_q_a.delete(); exp_q_b.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      last_a = '0; last_b = '0; cnt_m = '0; init_cnt = DEPTH;
   endtask

   task automatic step(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input logic ra, input logic [AW-1:0] raa,
                       input logic rb, input logic [AW-1:0] rab);
      logic run_m, ca, cb, exp_va, exp_vb, exp_conf;
      logic [DW-1:0] v;
      wen_a = wa; waddr_a = aa; wdata_a = da;
      wen_b = wb; waddr_b = ab; wdata_b = db;
      ren_a = ra; raddr_a = raa; ren_b = rb; raddr_b = rab;
      run_m    = (init_cnt == 0);
      exp_conf = run_m && wa && wb && (aa == ab);
      ca       = run_m && wa;
      cb       = run_m && wb && !exp_conf;
      exp_va   = run_m && ra;
      exp_vb   = run_m && rb;
      if (exp_va) begin
         v = model_mem[raa];
`ifdef MSGPASS_BUFF_FWD_EN
         if (ca && aa == raa) v = da; else if (cb && ab == raa) v = db;
`endif
         exp_q_a.push_back(v);
      end
      if (exp_vb) begin
         v = model_mem[rab];
`ifdef MSGPASS_BUFF_FWD_EN
         if (ca && aa == rab) v = da; else if (cb && ab == rab) v = db;
`endif
         exp_q_b.push_back(v);
      end
      if (exp_conf && cnt_m != '1) cnt_m = cnt_m + 1'b1;
      if (!run_m) init_cnt--;
      @(posedge clk); #1;
      if (cb) model_mem[ab] = db;
      if (ca) model_mem[aa] = da;
      check("init_busy", 32'(init_busy), 32'(init_cnt != 0));
      check("dbg_state", 32'(dbg_state), 32'(init_cnt == 0));
      check("conflict", 32'(conflict), 32'(exp_conf));
      check("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
      check("rvalid_a", 32'(rvalid_a), 32'(exp_va));
      check("rvalid_b", 32'(rvalid_b), 32'(exp_vb));
      if (exp_va && exp_q_a.size() > 0) last_a = exp_q_a.pop_front();
      if (exp_vb && exp_q_b.size() > 0) last_b = exp_q_b.pop_front();
      check("rdata_a", 32'(rdata_a), 32'(last_a));
      check("rdata_b", 32'(rdata_b), 32'(last_b));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      init_cnt = DEPTH;
      cnt_m    = '0;
      do_reset(1'b0);
      idle(DEPTH);

      // Whole memory reads back as zero after init, both ports.
      for (int i = 0; i < DEPTH; i++)
         step(0, 0, 0, 0, 0, 0, 1, AW'(i), 1, AW'(DEPTH-1-i));
      idle(1);

      // Same-address collision: A wins, B dropped.
      step(1, 6'd5, 8'hA5, 1, 6'd5, 8'h3C, 0, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 0, 1, 6'd5, 1, 6'd5);
      // Different addresses: both commit.
      step(1, 6'd1, 8'h10, 1, 6'd2, 8'h20, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 6'd1, 1, 6'd2);
      // Three more collisions drive the 2-bit counter to saturation.
      step(1, 6'd7, 8'h01, 1, 6'd7, 8'h02, 0, 0, 0, 0);
      step(1, 6'd8, 8'h03, 1, 6'd8, 8'h04, 0, 0, 0, 0);
      idle(1);
      step(1, 6'd3, 8'h05, 1, 6'd3, 8'h06, 1, 6'd3, 1, 6'd7);
      idle(1);

      // Read-during-write to address 9.
      step(1, 6'd9, 8'h11, 0, 0, 0, 0, 0, 0, 0);
      step(1, 6'd9, 8'h77, 0, 0, 0, 1, 6'd9, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 6'd9, 1, 6'd9);
      step(0, 0, 0, 1, 6'd12, 8'h5A, 0, 0, 1, 6'd12);
      idle(1);

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 1), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)),
              $urandom_range(0, 1), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)),
              $urandom_range(0, 1), AW'($urandom_range(0, 7)),
              $urandom_range(0, 1), AW'($urandom_range(0, 7)));

      // Reset mid-RUN with reads in flight, then again partway through INIT.
      step(1, 6'd9, 8'h99, 0, 0, 0, 1, 6'd5, 1, 6'd9);
      do_reset(1'b1);
      step(0, 0, 0, 0, 0, 0, 1, 6'd5, 1, 6'd9);
      idle(29);
      do_reset(1'b1);
      idle(DEPTH);
      for (int i = 0; i < 16; i++)
         step(0, 0, 0, 0, 0, 0, 1, AW'(i), 1, AW'(i + 16));
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
